frame_accumulator: RTL and testbench



---
 rtl/frame_accumulator.sv | 66 ++++++
 tb/tb_frame_accumulator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/frame_accumulator.sv
// Frame averager: sums FRAME_LEN signed samples and emits their mean one cycle after the frame's last sample.
// No backpressure; accepts one sample per cycle. Define FRAME_ACC_ROUND_EN to round half toward +inf instead of flooring.
module frame_accumulator #(
  parameter int DATA_W    = 25,
  parameter int FRAME_LEN = 16,
  localparam int CNT_W    = $clog2(FRAME_LEN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     in_valid,
  input  logic                     frame_sync,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         sample_cnt
);

  localparam int ACC_W = DATA_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  din_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [DATA_W-1:0] mean;
  logic                     first;
  logic                     last;

  always_comb begin
    din_ext = ACC_W'(data_in);
    sum     = acc + din_ext;
    first   = (sample_cnt == '0) || frame_sync;
    last    = (sample_cnt == LAST_CNT) && !frame_sync;
  end

`ifdef FRAME_ACC_ROUND_EN
  // One extra bit keeps sum + half from wrapping at the positive extreme.
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(2 ** (CNT_W - 1));
  logic signed [ACC_W:0] rsum;
  assign rsum = $signed({sum[ACC_W-1], sum}) + HALF;
  assign mean = DATA_W'(rsum >>> CNT_W);
`else
  assign mean = DATA_W'(sum >>> CNT_W);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      sample_cnt <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        acc <= first ? din_ext : sum;
        // Counter width equals log2(FRAME_LEN), so the increment wraps to 0 after the last sample.
        if (frame_sync) sample_cnt <= CNT_W'(1);
        else            sample_cnt <= sample_cnt + 1'b1;
        if (last) begin
          out_valid <= 1'b1;
          data_out  <= mean;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_accumulator.sv
// Directed bench for frame_accumulator with FRAME_LEN=4; expected values are hand-computed per build.
module tb_frame_accumulator;

  localparam int DATA_W    = 25;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 2;
`ifdef FRAME_ACC_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int E1 = RND ? 26 : 25;   // 10+20+30+42 = 102
  localparam int E2 = RND ? -1 : -2;   // -5
  localparam int E4 = RND ? 9 : 8;     // 7+8+9+10 = 34
  localparam int E6 = RND ? 15 : 14;   // 50+2+3+4 = 59
  localparam int E5 = RND ? 3 : 2;     // 1+2+3+4 = 10
  localparam int PMAX = 16777215;
  localparam int NMIN = -16777216;

  logic                     clk = 1'b0;
  logic                     reset;
  logic signed [DATA_W-1:0] data_in;
  logic                     in_valid;
  logic                     frame_sync;
  logic signed [DATA_W-1:0] data_out;
  logic                     out_valid;
  logic [CNT_W-1:0]         sample_cnt;

  frame_accumulator #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .frame_sync(frame_sync), .data_out(data_out), .out_valid(out_valid),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit vld; bit fs; int din;
    bit exp_ov; int exp_out; int exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic add(input bit rst, input bit vld, input bit fs, input int din,
                     input bit ov, input int dout, input int cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.fs = fs; v.din = din;
    v.exp_ov = ov; v.exp_out = dout; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit vld, input bit fs, input int din);
    @(negedge clk);
    reset = rst; in_valid = vld; frame_sync = fs; data_in = DATA_W'(din);
    @(posedge clk);
    #1;
  endtask

  int strobes;
  int idx0;
  int idx1;
  int val0;
  int val1;

  initial begin
    reset = 1'b1; in_valid = 1'b0; frame_sync = 1'b0; data_in = '0;

    // reset held, then idle
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // 10,20,30,42 back to back
    add(0, 1, 0, 10, 0, 0, 1);
    add(0, 1, 0, 20, 0, 0, 2);
    add(0, 1, 0, 30, 0, 0, 3);
    add(0, 1, 0, 42, 1, E1, 0);
    add(0, 0, 0, 0, 0, E1, 0);
    // -1,-1,-1,-2 with two idle cycles between; frame_sync without valid is ignored
    add(0, 1, 0, -1, 0, E1, 1);
    add(0, 0, 1, 999, 0, E1, 1);
    add(0, 0, 0, 0, 0, E1, 1);
    add(0, 1, 0, -1, 0, E1, 2);
    add(0, 0, 0, 0, 0, E1, 2);
    add(0, 0, 0, 0, 0, E1, 2);
    add(0, 1, 0, -1, 0, E1, 3);
    add(0, 0, 0, 0, 0, E1, 3);
    add(0, 0, 0, 0, 0, E1, 3);
    add(0, 1, 0, -2, 1, E2, 0);
    add(0, 0, 0, 0, 0, E2, 0);
    // full-scale frames back to back
    add(0, 1, 0, PMAX, 0, E2, 1);
    add(0, 1, 0, PMAX, 0, E2, 2);
    add(0, 1, 0, PMAX, 0, E2, 3);
    add(0, 1, 0, PMAX, 1, PMAX, 0);
    add(0, 1, 0, NMIN, 0, PMAX, 1);
    add(0, 1, 0, NMIN, 0, PMAX, 2);
    add(0, 1, 0, NMIN, 0, PMAX, 3);
    add(0, 1, 0, NMIN, 1, NMIN, 0);
    add(0, 0, 0, 0, 0, NMIN, 0);
    // frame_sync mid-frame discards 100,100
    add(0, 1, 0, 100, 0, NMIN, 1);
    add(0, 1, 0, 100, 0, NMIN, 2);
    add(0, 1, 1, 7, 0, NMIN, 1);
    add(0, 1, 0, 8, 0, NMIN, 2);
    add(0, 1, 0, 9, 0, NMIN, 3);
    add(0, 1, 0, 10, 1, E4, 0);
    // frame_sync on what would be the last sample suppresses the strobe
    add(0, 1, 0, 1, 0, E4, 1);
    add(0, 1, 0, 1, 0, E4, 2);
    add(0, 1, 0, 1, 0, E4, 3);
    add(0, 1, 1, 50, 0, E4, 1);
    add(0, 1, 0, 2, 0, E4, 2);
    add(0, 1, 0, 3, 0, E4, 3);
    add(0, 1, 0, 4, 1, E6, 0);
    // reset mid-frame with a valid sample present
    add(0, 1, 0, 5, 0, E6, 1);
    add(0, 1, 0, 5, 0, E6, 2);
    add(1, 1, 0, 7, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1);
    add(0, 1, 0, 2, 0, 0, 2);
    add(0, 1, 0, 3, 0, 0, 3);
    add(0, 1, 0, 4, 1, E5, 0);
    add(0, 0, 0, 0, 0, E5, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].fs, vecs[i].din);
      check($sformatf("v%0d out_valid", i), int'(out_valid), int'(vecs[i].exp_ov));
      check($sformatf("v%0d data_out", i), int'(data_out), vecs[i].exp_out);
      check($sformatf("v%0d sample_cnt", i), int'(sample_cnt), vecs[i].exp_cnt);
    end

    // Eight samples with no bubbles: strobes must land 4 cycles apart.
    strobes = 0; idx0 = -1; idx1 = -1; val0 = 0; val1 = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, i < 8, 0, (i < 4) ? 3 : -3);
      if (out_valid) begin
        if (strobes == 0) begin idx0 = i; val0 = int'(data_out); end
        else if (strobes == 1) begin idx1 = i; val1 = int'(data_out); end
        strobes++;
      end
    end
    check("b2b strobe count", strobes, 2);
    check("b2b first strobe cycle", idx0, 3);
    check("b2b second strobe cycle", idx1, 7);
    check("b2b first mean", val0, 3);
    check("b2b second mean", val1, -3);
    check("b2b final cnt", int'(sample_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
